// File: rtl/frame_deframer.sv
// frame_deframer
//   Hunts a serial bit stream for a sync word, then reads a length byte,
//   that many payload bytes and, when DEFRAMER_CRC_EN is defined, a trailing
//   CRC-8 check byte (poly 0x07, init 0x00, over length + payload).
//   Payload leaves as a byte stream with per-frame done/error strobes.
//
//   Optional feature macro: DEFRAMER_CRC_EN (undefined: no CHECK state, no CRC).
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-low reset
//   i_din         recovered data bit, qualified by i_vin
//   i_vin         bit-valid strobe, one bit consumed per cycle when high
//   o_byte_out    assembled payload byte, holds between strobes
//   o_byte_valid  one-cycle strobe, o_byte_out valid
//   o_byte_last   with o_byte_valid on the final payload byte
//   o_frame_done  one-cycle strobe, frame accepted
//   o_frame_err   one-cycle strobe, frame aborted or rejected
//   o_locked      high in every state except HUNT
module frame_deframer #(
  parameter logic [7:0] SYNC_WORD = 8'h7E,
  parameter int         MAX_LEN   = 64,
  parameter int         TIMEOUT   = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_din,
  input  logic       i_vin,
  output logic [7:0] o_byte_out,
  output logic       o_byte_valid,
  output logic       o_byte_last,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_locked
);

  localparam int         IDLE_W    = $clog2(TIMEOUT);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(TIMEOUT - 1);

`ifdef DEFRAMER_CRC_EN
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_sr, w_sr_nxt;
  logic [2:0]        r_bitcnt, w_bitcnt_nxt;
  logic [7:0]        r_bytecnt, w_bytecnt_nxt;
  logic [7:0]        r_len, w_len_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [7:0]        r_byte_out, w_byte_out_nxt;
  logic              r_byte_valid, w_byte_valid_nxt;
  logic              r_byte_last, w_byte_last_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_locked;
  logic              w_to_hunt;
  logic              w_last_byte;

  // Shift register value after consuming the current bit.
  logic [7:0] w_shift;
  logic       w_bit8;
  assign w_shift = {r_sr[6:0], i_din};
  assign w_bit8  = i_vin && (r_bitcnt == 3'd7);
  assign w_last_byte = (r_bytecnt == r_len - 8'd1);

`ifdef DEFRAMER_CRC_EN
  logic [7:0] r_crc, w_crc_nxt, w_crc_step;
  logic       w_fb;
  assign w_fb       = r_crc[7] ^ i_din;
  assign w_crc_step = {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_bitcnt_nxt     = r_bitcnt;
    w_bytecnt_nxt    = r_bytecnt;
    w_len_nxt        = r_len;
    w_idle_nxt       = r_idle;
    w_byte_out_nxt   = r_byte_out;
    w_byte_valid_nxt = 1'b0;
    w_byte_last_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_to_hunt        = 1'b0;
`ifdef DEFRAMER_CRC_EN
    w_crc_nxt        = r_crc;
`endif

    // In-frame states share bit collection and the idle counter.
    if (r_state != S_HUNT) begin
      if (i_vin) begin
        w_idle_nxt   = '0;
        w_bitcnt_nxt = r_bitcnt + 3'd1;
        w_sr_nxt     = w_shift;
      end else begin
        w_idle_nxt   = r_idle + 1'b1;
      end
    end

    unique case (r_state)
      S_HUNT: begin
        if (i_vin) begin
          w_sr_nxt = w_shift;
          if (w_shift == SYNC_WORD) begin
            w_state_nxt  = S_LEN;
            w_bitcnt_nxt = 3'd0;
            w_idle_nxt   = '0;
`ifdef DEFRAMER_CRC_EN
            w_crc_nxt    = 8'h00;
`endif
          end
        end
      end
      S_LEN: begin
        if (i_vin) begin
`ifdef DEFRAMER_CRC_EN
          w_crc_nxt = w_crc_step;
`endif
          if (w_bit8) begin
            if (w_shift == 8'd0 || w_shift > MAX_LEN_B) begin
              w_frame_err_nxt = 1'b1;
              w_to_hunt       = 1'b1;
            end else begin
              w_len_nxt     = w_shift;
              w_bytecnt_nxt = 8'd0;
              w_state_nxt   = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (i_vin) begin
`ifdef DEFRAMER_CRC_EN
          w_crc_nxt = w_crc_step;
`endif
          if (w_bit8) begin
            w_byte_out_nxt   = w_shift;
            w_byte_valid_nxt = 1'b1;
            w_byte_last_nxt  = w_last_byte;
            w_bytecnt_nxt    = r_bytecnt + 8'd1;
            if (w_last_byte) begin
`ifdef DEFRAMER_CRC_EN
              w_state_nxt = S_CHECK;
`else
              w_frame_done_nxt = 1'b1;
              w_to_hunt        = 1'b1;
`endif
            end
          end
        end
      end
`ifdef DEFRAMER_CRC_EN
      S_CHECK: begin
        // Check bits are compared against the CRC, not folded into it.
        if (w_bit8) begin
          if (w_shift == r_crc) w_frame_done_nxt = 1'b1;
          else                  w_frame_err_nxt  = 1'b1;
          w_to_hunt = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // Terminal idle count: only reachable on a cycle without vin, so a
    // coincident vin always wins.
    if (r_state != S_HUNT && !i_vin && r_idle == IDLE_TC) begin
      w_frame_err_nxt = 1'b1;
      w_to_hunt       = 1'b1;
    end

    // Entering HUNT clears sr so a fresh sync must be shifted in.
    if (w_to_hunt) begin
      w_state_nxt  = S_HUNT;
      w_sr_nxt     = 8'h00;
      w_bitcnt_nxt = 3'd0;
      w_idle_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_HUNT;
      r_sr         <= 8'h00;
      r_bitcnt     <= 3'd0;
      r_bytecnt    <= 8'd0;
      r_len        <= 8'd0;
      r_idle       <= '0;
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
`ifdef DEFRAMER_CRC_EN
      r_crc        <= 8'h00;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sr         <= w_sr_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_bytecnt    <= w_bytecnt_nxt;
      r_len        <= w_len_nxt;
      r_idle       <= w_idle_nxt;
      r_byte_out   <= w_byte_out_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_last  <= w_byte_last_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_locked     <= (w_state_nxt != S_HUNT);
`ifdef DEFRAMER_CRC_EN
      r_crc        <= w_crc_nxt;
`endif
    end
  end

  assign o_byte_out   = r_byte_out;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_last  = r_byte_last;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_locked     = r_locked;

endmodule

// File: tb/tb_frame_deframer.sv
// tb_frame_deframer
//   Drives frames, noise, idle gaps, timeouts and a mid-frame reset into
//   frame_deframer. The driver pushes each expected strobe (with the cycle it
//   must appear in) onto a scoreboard; a monitor pops on every DUT strobe.
//   Follows DEFRAMER_CRC_EN the same way the design does.
module tb_frame_deframer;
  localparam logic [7:0] SYNC    = 8'h7E;
  localparam int         MAX_LEN = 64;
  localparam int         TIMEOUT = 1024;

  logic       clk = 1'b0, rst = 1'b0, din = 1'b0, vin = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, byte_last, frame_done, frame_err, locked;

  frame_deframer #(.SYNC_WORD(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_vin(vin),
    .o_byte_out(byte_out), .o_byte_valid(byte_valid), .o_byte_last(byte_last),
    .o_frame_done(frame_done), .o_frame_err(frame_err), .o_locked(locked));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         bv, last, done, err;
    longint     at;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         n_tests = 0, n_fail = 0;
  bit         g_gaps = 1'b1;
  logic [7:0] dir_pay[$];

  function automatic ev_t mk(input logic [7:0] b, input bit bv, input bit last,
                             input bit done, input bit err);
    ev_t e;
    e.b = b; e.bv = bv; e.last = last; e.done = done; e.err = err; e.at = 0;
    return e;
  endfunction

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input logic [7:0] m[$]);
    logic [8:0] r = 9'h000;
    for (int k = 0; k < m.size() + 1; k++)
      for (int j = 7; j >= 0; j--) begin
        r = {r[7:0], (k < m.size()) ? m[k][j] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    din = b;
    vin = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'($urandom), 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit has_ev, input ev_t ev);
    ev_t e = ev;
    for (int i = 7; i >= 0; i--) begin
      if (g_gaps && ($urandom % 4 == 0)) idle($urandom_range(1, 3));
      drive(b[i], 1'b1);
      if (i == 0 && has_ev) begin
        e.at = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_plain(input logic [7:0] b);
    send_byte(b, 1'b0, mk(8'h00, 0, 0, 0, 0));
  endtask

  // Sync, length, payload (random or dir_pay) and, in the CRC build, a check
  // byte equal to the true CRC xor crc_xor.
  task automatic send_frame(input logic [7:0] len, input bit use_dir, input logic [7:0] crc_xor);
    logic [7:0] msg[$];
    logic [7:0] c;
    bit         last;
    send_plain(SYNC);
    if (len == 8'd0 || int'(len) > MAX_LEN) begin
      send_byte(len, 1'b1, mk(8'h00, 0, 0, 0, 1));
      idle(1);
      check("locked_after_bad_len", {31'd0, locked}, 32'd0);
      return;
    end
    msg = {len};
    for (int i = 0; i < int'(len); i++) msg.push_back(use_dir ? dir_pay[i] : 8'($urandom));
    send_plain(len);
    if ($urandom % 2 == 0) begin
      idle(1);
      check("locked_in_frame", {31'd0, locked}, 32'd1);
    end
    for (int i = 1; i <= int'(len); i++) begin
      last = (i == int'(len));
`ifdef DEFRAMER_CRC_EN
      send_byte(msg[i], 1'b1, mk(msg[i], 1, last, 0, 0));
`else
      send_byte(msg[i], 1'b1, mk(msg[i], 1, last, last, 0));
`endif
    end
    c = crc_model(msg) ^ crc_xor;
`ifdef DEFRAMER_CRC_EN
    send_byte(c, 1'b1, mk(8'h00, 0, 0, crc_xor == 8'h00, crc_xor != 8'h00));
`endif
  endtask

  // Random bits with no sync match anywhere before the sync that follows,
  // counting the zeros left in the cleared shift register.
  task automatic send_noise(input int n);
    logic       w[$];
    logic [7:0] win;
    bit         ok;
    do begin
      w = {};
      for (int i = 0; i < n; i++) w.push_back(1'($urandom));
      ok  = 1'b1;
      win = 8'h00;
      for (int i = 0; i < n + 8; i++) begin
        win = {win[6:0], (i < n) ? w[i] : SYNC[7 - (i - n)]};
        if (win == SYNC && i != n + 7) ok = 1'b0;
      end
    end while (!ok);
    foreach (w[i]) drive(w[i], 1'b1);
  endtask

  // Monitor: every strobe cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].at < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_missing want cyc=%0d v=%b l=%b d=%b e=%b byte=%h (now %0d)",
               sb[0].at, sb[0].bv, sb[0].last, sb[0].done, sb[0].err, sb[0].b, cyc);
      void'(sb.pop_front());
    end
    if (byte_valid || frame_done || frame_err) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected cyc=%0d v=%b l=%b d=%b e=%b byte=%h",
                 cyc, byte_valid, byte_last, frame_done, frame_err, byte_out);
      end else begin
        mon_e = sb.pop_front();
        if (byte_valid !== mon_e.bv || byte_last !== mon_e.last || frame_done !== mon_e.done ||
            frame_err !== mon_e.err || (mon_e.bv && byte_out !== mon_e.b) || cyc != mon_e.at) begin
          n_fail++;
          $display("FAIL strobe_event got cyc=%0d v=%b l=%b d=%b e=%b byte=%h want cyc=%0d v=%b l=%b d=%b e=%b byte=%h",
                   cyc, byte_valid, byte_last, frame_done, frame_err, byte_out,
                   mon_e.at, mon_e.bv, mon_e.last, mon_e.done, mon_e.err, mon_e.b);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cycle budget exhausted at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] len, x;
    int         r;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_byte_out", {24'd0, byte_out}, 32'h00);
    check("rst_strobes", {28'd0, byte_valid, byte_last, frame_done, frame_err}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Reference frame 03 A1 B2 C3 (good check byte in the CRC build)
    dir_pay = {8'hA1, 8'hB2, 8'hC3};
    send_frame(8'd3, 1'b1, 8'h00);
    idle(1);
    check("locked_after_frame", {31'd0, locked}, 32'd0);
`ifdef DEFRAMER_CRC_EN
    // Same frame, check byte off by one bit
    send_frame(8'd3, 1'b1, 8'h01);
    idle(1);
`endif
    dir_pay = {8'h55};
    send_frame(8'd1, 1'b1, 8'h00);

    // Length boundaries
    send_frame(8'd0, 1'b0, 8'h00);
    send_frame(8'(MAX_LEN + 1), 1'b0, 8'h00);
    send_frame(8'(MAX_LEN), 1'b0, 8'h00);

    // Noise without sync, then lock
    idle(1);
    send_noise(60);
    idle(1);
    check("locked_noise", {31'd0, locked}, 32'd0);
    send_frame(8'd2, 1'b0, 8'h00);

    // Sync misaligned by 4 bits (F7 E0 ...)
    repeat (4) drive(1'b1, 1'b1);
    send_frame(8'd3, 1'b0, 8'h00);

    // Idle timeout at TIMEOUT cycles
    g_gaps = 1'b0;
    send_plain(SYNC);
    send_plain(8'd2);
    send_byte(8'hA1, 1'b1, mk(8'hA1, 1, 0, 0, 0));
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1'b0, 1'b0);
      if (i == TIMEOUT - 1) begin
        mon_e = mk(8'h00, 0, 0, 0, 1);
        mon_e.at = cyc + 1;
        sb.push_back(mon_e);
      end
    end
    idle(1);
    check("locked_after_timeout", {31'd0, locked}, 32'd0);

    // One cycle short of the timeout, then vin
    send_plain(SYNC);
    send_plain(8'd2);
    send_byte(8'hA1, 1'b1, mk(8'hA1, 1, 0, 0, 0));
    idle(TIMEOUT - 1);
    check("locked_before_tc", {31'd0, locked}, 32'd1);
`ifdef DEFRAMER_CRC_EN
    send_byte(8'hB2, 1'b1, mk(8'hB2, 1, 1, 0, 0));
    send_byte(crc_model({8'h02, 8'hA1, 8'hB2}), 1'b1, mk(8'h00, 0, 0, 1, 0));
`else
    send_byte(8'hB2, 1'b1, mk(8'hB2, 1, 1, 1, 0));
`endif

    // Reset in PAYLOAD
    send_plain(SYNC);
    send_plain(8'd8);
    send_byte(8'hC5, 1'b1, mk(8'hC5, 1, 0, 0, 0));
    repeat (3) drive(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_byte_out", {24'd0, byte_out}, 32'h00);
    check("mrst_strobes", {28'd0, byte_valid, byte_last, frame_done, frame_err}, 32'd0);
    check("mrst_locked", {31'd0, locked}, 32'd0);
    send_frame(8'd5, 1'b0, 8'h00);
    g_gaps = 1'b1;

    // Randomised frames, some back-to-back
    for (int n = 0; n < 25; n++) begin
      r = int'($urandom % 100);
      if (r < 12)      len = ($urandom % 2 == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
      else if (r < 25) len = 8'($urandom_range(MAX_LEN - 4, MAX_LEN));
      else             len = 8'($urandom_range(1, 10));
      x = ($urandom % 5 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom % 3 == 0) send_noise($urandom_range(1, 24));
      send_frame(len, 1'b0, x);
      if ($urandom % 2 == 0) begin
        idle(1);
        check("locked_idle", {31'd0, locked}, 32'd0);
      end
    end

    idle(20);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_deframer.md
# frame_deframer

- Consumes the recovered serial bit stream (`din`/`vin`) from the optical receiver stage.
- Hunts for a sync word, then reads a length byte, payload bytes and (optionally) a CRC-8 byte.
- Presents payload as a byte stream with per-frame done/error strobes.
- Sits between the receiver and the packet/consumer logic on fpga2.

## Interface
- `SYNC_WORD`, 8'h7E, frame start pattern, MSB-first.
- `MAX_LEN`, 64, largest legal payload length in bytes (1..255).
- `TIMEOUT`, 1024, clocks without a `vin` strobe before an in-frame abort (≥2).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low: reset when `rst`==0 at a `posedge clk`.
- `din`  in  1  recovered data bit; qualified by `vin`.
- `vin`  in  1  bit-valid strobe; one bit consumed per cycle with `vin`==1.
- `byte_out`  out  8  assembled payload byte; holds its value between strobes.
- `byte_valid`  out  1  one-cycle strobe; `byte_out` is valid.
- `byte_last`  out  1  asserted with `byte_valid` on the final payload byte.
- `frame_done`  out  1  one-cycle strobe; frame accepted.
- `frame_err`  out  1  one-cycle strobe; frame aborted or rejected.
- `locked`  out  1  high in every state except HUNT.

## Operation
- Bits are shifted MSB-first into an 8-bit register `sr <= {sr[6:0], din}` on each `vin`.
- States and transitions:
  - HUNT:
    - Shifts on every `vin`.
    - When the post-shift value equals `SYNC_WORD`, go to LEN; clear the bit counter and CRC.
    - Entry into HUNT clears `sr`, so 8 fresh bits are needed before a match.
  - LEN: collect 8 bits into length L.
    - L==0 or L>`MAX_LEN` → `frame_err`, go to HUNT.
    - Otherwise go to PAYLOAD with byte count 0.
  - PAYLOAD: every 8th bit emits `byte_out`/`byte_valid`.
    - `byte_last` is set when count==L-1.
    - After the last byte, go to CHECK (CRC build) or HUNT with `frame_done` (no-CRC build).
  - CHECK: collect 8 bits.
    - Equal to the running CRC → `frame_done`.
    - Otherwise → `frame_err`.
    - Then go to HUNT.
- Idle timeout:
  - In LEN, PAYLOAD and CHECK, a counter increments each cycle without `vin` and resets on `vin`.
  - Reaching `TIMEOUT` → `frame_err`, go to HUNT.
  - `vin` in the same cycle as the terminal count wins: no error, counter reset.
- The bit counter is 3 bits and wraps 7→0; the byte counter is 8 bits.
- Reset mid-frame discards all partial state; no strobe is emitted.

## Timing
- Reset values:
  - `byte_out`=8'h00; `byte_valid`, `byte_last`, `frame_done`, `frame_err`, `locked` all 0.
  - State HUNT, `sr`=0, CRC=0, all counters 0.
- All outputs are registered.
- Latency: when the completing bit is sampled at edge k, the strobe and byte are visible for exactly the cycle after edge k.
- Without CRC, `frame_done` coincides with the last `byte_valid`/`byte_last`.
- With CRC, `frame_done` or `frame_err` follows the 8th check bit.
- `locked` rises the cycle after the sync match and falls the cycle after the terminating strobe.
- At most one of `frame_done`/`frame_err` is high in any cycle.
- No backpressure: the consumer must accept one byte per strobe. Strobes are at least 8 `vin` strobes apart.
- Back-to-back frames are supported; the next sync may begin on the bit immediately after the check/last bit.

## Configuration
- Macro: `DEFRAMER_CRC_EN`.
- Defined:
  - CRC-8, poly 0x07, init 0x00, updated bitwise: `fb=crc[7]^din; crc={crc[6:0],0}^(fb?8'h07:0)`.
  - Covers the length byte and the payload bits; sync is excluded.
  - The trailing check byte is required (CHECK state).
- Undefined:
  - CHECK state and CRC logic are absent; no trailing byte is expected.
  - `frame_err` arises only from bad length or timeout.

## Test plan
- CRC build, bits of 7E 03 A1 B2 C3 3B with `vin` every cycle:
  - `byte_valid` ×3 with A1, B2, C3.
  - `byte_last` on C3.
  - `frame_done` one cycle after the final bit; `frame_err` never asserted.
- Same frame with check byte 3A → three bytes emitted, then `frame_err`; no `frame_done`.
- Length edge cases:
  - 7E 00 → `frame_err` after the 8th length bit.
  - 7E 41 (`MAX_LEN`=64) → `frame_err`.
  - 7E 40 → accepted into PAYLOAD.
- Noise then sync:
  - Random bits containing no 7E → `locked` stays 0.
  - Stream F7 E0 … (sync misaligned by 4 bits) → lock on the bit-aligned 7E.
- Timeout:
  - After 7E 02 A1, hold `vin`=0 for 1024 cycles → `frame_err`, `locked`=0.
  - Hold `vin`=0 for 1023 cycles and then assert `vin` → no error.
- Mid-frame reset:
  - `rst`=0 for one cycle during PAYLOAD → all outputs 0 next cycle.
  - A subsequent full frame is received correctly.
  - No-CRC build: 7E 01 55 → byte 55 with `byte_last` and `frame_done` in the same cycle.
